// File: rtl/std_fifo_fwft_adapter.sv
// -----------------------------------------------------------------------------
// std_fifo_fwft_adapter
//
// Presents a first-word-fall-through read port in front of a standard-mode
// FIFO whose read data arrives READ_LATENCY cycles after the read strobe.
// Words are prefetched into a small circular buffer. A valid shift register
// tracks reads still in flight, so issue never exceeds the buffer space.
//
// Parameters
//   READ_LATENCY : cycles from standard_fifo_rd_en sampled to data valid (1..8)
//   DOUT_WIDTH   : data width (1..1024)
//   BUF_DEPTH    : prefetch buffer entries (>= 2; READ_LATENCY+2 for 1 word/clk)
//   CNT_WIDTH    : width of fwft_data_count (derived from BUF_DEPTH)
//
// Ports
//   clk                 in   sole clock, rising edge
//   arst                in   asynchronous active-high reset
//   flush               in   synchronous: empty buffer, drop in-flight reads
//   standard_fifo_dout  in   read data from the standard FIFO
//   standard_fifo_empty in   standard FIFO empty
//   standard_fifo_rd_en out  read strobe to the standard FIFO
//   fwft_fifo_dout      out  head-of-buffer word
//   fwft_fifo_empty     out  buffer holds no word
//   fwft_fifo_rd_en     in   consumer pop / acknowledge
//   fwft_data_count     out  words held in the buffer (in-flight excluded)
//   underflow           out  sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module std_fifo_fwft_adapter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned DOUT_WIDTH   = 8,
  parameter int unsigned BUF_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH    = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  flush,
  input  logic [DOUT_WIDTH-1:0] standard_fifo_dout,
  input  logic                  standard_fifo_empty,
  output logic                  standard_fifo_rd_en,
  output logic [DOUT_WIDTH-1:0] fwft_fifo_dout,
  output logic                  fwft_fifo_empty,
  input  logic                  fwft_fifo_rd_en,
  output logic [CNT_WIDTH-1:0]  fwft_data_count,
  output logic                  underflow
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned IF_W  = $clog2(READ_LATENCY + 1);
  localparam int unsigned SUM_W = CNT_WIDTH + IF_W + 1;

  logic [READ_LATENCY-1:0] r_valid;
  logic [DOUT_WIDTH-1:0]   r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_WIDTH-1:0]    r_count;
  logic                    r_underflow;

  logic [READ_LATENCY-1:0] w_valid_nxt;
  logic [IF_W-1:0]         w_inflight;
  logic [SUM_W-1:0]        w_reserved;
  logic                    w_empty;
  logic                    w_cap;
  logic                    w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    // Explicit wrap so non-power-of-two depths are legal.
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_empty = (r_count == '0);
  assign w_cap   = r_valid[READ_LATENCY-1];
  assign w_pop   = fwft_fifo_rd_en && !w_empty;

  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + IF_W'(r_valid[i]);
    end
  end

  always_comb begin
    w_valid_nxt    = '0;
    w_valid_nxt[0] = standard_fifo_rd_en;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      w_valid_nxt[i] = r_valid[i-1];
    end
  end

  // Space is reserved for every read in flight; a same-cycle pop earns no
  // credit, which keeps the issue path free of the consumer's rd_en.
  assign w_reserved          = SUM_W'(r_count) + SUM_W'(w_inflight);
  assign standard_fifo_rd_en = !standard_fifo_empty && !flush &&
                               (w_reserved < SUM_W'(BUF_DEPTH));

  assign fwft_fifo_dout  = r_mem[r_rd_ptr];
  assign fwft_fifo_empty = w_empty;
  assign fwft_data_count = r_count;
  assign underflow       = r_underflow;

  // In-flight tracker
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_nxt;
    end
  end

  // Pointers and occupancy; flush wins over a capture on the same edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_cap) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_cap, w_pop})
        2'b10:   r_count <= r_count + CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared only by arst so the head word reads 0 out of reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_cap && !flush) begin
      r_mem[r_wr_ptr] <= standard_fifo_dout;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_underflow <= 1'b0;
    end else if (fwft_fifo_rd_en && w_empty) begin
      r_underflow <= 1'b1;
    end
  end

  // The issue rule reserves a slot for every in-flight read, so a capture
  // can never land in a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (arst)
    (w_cap && !flush) |-> (r_count != CNT_WIDTH'(BUF_DEPTH)));

endmodule
